// File: rtl/temp_alarm_ctrl.sv
// Temperature band classifier with persistence filtering, latched
// emergency alarm, sample watchdog and BCD validity checking.
module temp_alarm_ctrl #(
   parameter int UP_CNT   = 2,
   parameter int DOWN_CNT = 4,
   parameter int TIMEOUT  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_valid,
   input  logic [3:0] bcd_tens,
   input  logic [3:0] bcd_units,
   input  logic       sign,
   input  logic       ack,
   output logic       normal,
   output logic       border_line,
   output logic       warning,
   output logic       emergency,
   output logic       alarm,
   output logic       stale,
   output logic       bcd_err
);

   localparam int UW = $clog2(UP_CNT + 1);
   localparam int DW = $clog2(DOWN_CNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_NORM = 2'd0,
      S_BORD = 2'd1,
      S_WARN = 2'd2,
      S_EMER = 2'd3
   } band_e;

   band_e          s_q, s_d, cls;
   logic [UW-1:0]  up_q, up_d;
   logic [DW-1:0]  dn_q, dn_d, dn_sat;
   logic [TW-1:0]  wd_q, wd_d;
   logic [6:0]     val;
   logic           accept, reject;
   logic           set_alarm, alarm_d;

   assign accept = sample_valid && (bcd_tens <= 4'd9) && (bcd_units <= 4'd9);
   assign reject = sample_valid && !accept;
   assign val    = 7'(bcd_tens) * 7'd10 + 7'(bcd_units);

   always_comb begin
      cls = S_NORM;
      if (sign || val >= 7'd50) cls = S_EMER;
      else if (val >= 7'd47)    cls = S_WARN;
      else if (val >= 7'd40)    cls = S_BORD;
   end

   // Down counter pins at DOWN_CNT while the alarm holds us in emergency.
   assign dn_sat = (dn_q == DW'(DOWN_CNT)) ? dn_q : dn_q + DW'(1);

   always_comb begin
      s_d       = s_q;
      up_d      = up_q;
      dn_d      = dn_q;
      set_alarm = 1'b0;
      if (accept) begin
         if (cls == S_EMER && s_q != S_EMER) begin
            s_d       = S_EMER;
            set_alarm = 1'b1;
            up_d      = '0;
            dn_d      = '0;
         end else if (cls > s_q) begin
            dn_d = '0;
            if (up_q + UW'(1) == UW'(UP_CNT)) begin
               s_d  = cls;
               up_d = '0;
            end else begin
               up_d = up_q + UW'(1);
            end
         end else if (cls < s_q) begin
            up_d = '0;
            if (dn_sat == DW'(DOWN_CNT) && !(s_q == S_EMER && alarm)) begin
               s_d  = band_e'(s_q - 2'd1);
               dn_d = '0;
            end else begin
               dn_d = dn_sat;
            end
         end else begin
            up_d = '0;
            dn_d = '0;
         end
      end
   end

   assign alarm_d = set_alarm | (alarm & ~ack);

   always_comb begin
      wd_d = wd_q;
      if (accept)                    wd_d = '0;
      else if (wd_q != TW'(TIMEOUT)) wd_d = wd_q + TW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_q         <= S_NORM;
         up_q        <= '0;
         dn_q        <= '0;
         wd_q        <= '0;
         normal      <= 1'b1;
         border_line <= 1'b0;
         warning     <= 1'b0;
         emergency   <= 1'b0;
         alarm       <= 1'b0;
         stale       <= 1'b0;
         bcd_err     <= 1'b0;
      end else begin
         s_q         <= s_d;
         up_q        <= up_d;
         dn_q        <= dn_d;
         wd_q        <= wd_d;
         normal      <= (s_d == S_NORM);
         border_line <= (s_d == S_BORD);
         warning     <= (s_d == S_WARN);
         emergency   <= (s_d == S_EMER);
         alarm       <= alarm_d;
         stale       <= (wd_d == TW'(TIMEOUT));
         bcd_err     <= reject;
      end
   end

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// Directed bench for temp_alarm_ctrl: a per-cycle reference model
// plus literal checkpoints from hand-worked sequences.
module tb_temp_alarm_ctrl;

   localparam int UP = 2;
   localparam int DN = 4;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sample_valid = 1'b0;
   logic [3:0] bcd_tens = 4'd0;
   logic [3:0] bcd_units = 4'd0;
   logic       sign = 1'b0;
   logic       ack = 1'b0;
   logic       normal, border_line, warning, emergency;
   logic       alarm, stale, bcd_err;

   int pass_cnt = 0;
   int total_cnt = 0;

   temp_alarm_ctrl #(.UP_CNT(UP), .DOWN_CNT(DN), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .bcd_tens(bcd_tens), .bcd_units(bcd_units), .sign(sign),
      .ack(ack), .normal(normal), .border_line(border_line),
      .warning(warning), .emergency(emergency), .alarm(alarm),
      .stale(stale), .bcd_err(bcd_err)
   );

   always #5 clk = ~clk;

   // Reference model: band as an integer 0..3, plain counters.
   int m_band = 0;
   int m_up = 0;
   int m_dn = 0;
   int m_age = 0;
   bit m_alarm = 0;
   bit m_stale = 0;
   bit m_err = 0;

   function automatic int band_of(int t, int u, bit s);
      int v = t * 10 + u;
      if (s || v >= 50) return 3;
      if (v >= 47) return 2;
      if (v >= 40) return 1;
      return 0;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_band = 0; m_up = 0; m_dn = 0; m_age = 0;
         m_alarm = 0; m_stale = 0; m_err = 0;
      end else begin
         bit good;
         bit was_alarm;
         bit raised;
         int c;
         good = sample_valid && bcd_tens < 10 && bcd_units < 10;
         m_err = sample_valid && !good;
         was_alarm = m_alarm;
         raised = 0;
         if (good) begin
            c = band_of(int'(bcd_tens), int'(bcd_units), sign);
            if (c == 3 && m_band != 3) begin
               m_band = 3; raised = 1; m_up = 0; m_dn = 0;
            end else if (c > m_band) begin
               m_dn = 0;
               m_up++;
               if (m_up >= UP) begin m_band = c; m_up = 0; end
            end else if (c < m_band) begin
               m_up = 0;
               if (m_dn < DN) m_dn++;
               if (m_dn >= DN && !(m_band == 3 && was_alarm)) begin
                  m_band--; m_dn = 0;
               end
            end else begin
               m_up = 0; m_dn = 0;
            end
            m_age = 0;
         end else if (m_age < TO) begin
            m_age++;
         end
         if (raised) m_alarm = 1;
         else if (ack) m_alarm = 0;
         m_stale = (m_age == TO);
      end
   end

   function automatic logic [6:0] model_vec();
      return {m_band == 0, m_band == 1, m_band == 2, m_band == 3,
              m_alarm, m_stale, m_err};
   endfunction

   wire [6:0] dut_vec = {normal, border_line, warning, emergency,
                         alarm, stale, bcd_err};
   wire [3:0] bands = {normal, border_line, warning, emergency};

   task automatic chk(string nm, logic [6:0] act, logic [6:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (rst) chk("model", dut_vec, model_vec());
   end

   task automatic send(int t, int u, bit s, bit a);
      sample_valid = 1'b1;
      bcd_tens = 4'(t);
      bcd_units = 4'(u);
      sign = s;
      ack = a;
      @(negedge clk);
      sample_valid = 1'b0;
      sign = 1'b0;
      ack = 1'b0;
   endtask

   task automatic sendn(int t, int u, int n);
      for (int i = 0; i < n; i++) send(t, u, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_state", dut_vec, 7'b1000_000);
      rst = 1'b1;
      @(negedge clk);

      send(4, 5, 0, 0); send(2, 2, 0, 0); send(4, 5, 0, 0);
      chk("filter_45_22_45", 7'(bands), 7'b1000);
      send(2, 2, 0, 0); send(4, 5, 0, 0);
      chk("one_45_holds", 7'(bands), 7'b1000);
      send(4, 8, 0, 0);
      chk("skip_to_warning", 7'(bands), 7'b0010);

      send(5, 2, 0, 0);
      chk("emerg_52", {2'b0, bands, alarm}, 7'b0000011);
      sendn(3, 0, 6);
      chk("emerg_held", {2'b0, bands, alarm}, 7'b0000011);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("ack_clears", {6'b0, alarm}, 7'b0);
      chk("ack_keeps_band", 7'(bands), 7'b0001);
      send(3, 0, 0, 0);
      chk("first_after_ack", 7'(bands), 7'b0010);
      sendn(3, 0, 3);
      chk("warn_3_below", 7'(bands), 7'b0010);
      send(3, 0, 0, 0);
      chk("warn_to_border", 7'(bands), 7'b0100);

      send(0, 5, 1, 1);
      chk("neg_set_wins", {2'b0, bands, alarm}, 7'b0000011);

      @(posedge clk);
      #3 rst = 1'b0;
      #1 chk("async_reset", dut_vec, 7'b1000_000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      sendn(4, 8, 2);
      chk("to_warning", 7'(bands), 7'b0010);
      sendn(1, 0, 4);
      chk("step_one_a", 7'(bands), 7'b0100);
      sendn(1, 0, 3);
      chk("no_double_drop", 7'(bands), 7'b0100);
      send(1, 0, 0, 0);
      chk("step_one_b", 7'(bands), 7'b1000);

      send(4, 5, 0, 0);
      send(4, 10, 0, 0);
      chk("bcd_err_pulse", {6'b0, bcd_err}, 7'b1);
      @(negedge clk);
      chk("bcd_err_one_cycle", {6'b0, bcd_err}, 7'b0);
      repeat (13) @(negedge clk);
      chk("not_stale_yet", {6'b0, stale}, 7'b0);
      @(negedge clk);
      chk("stale_at_16", {6'b0, stale}, 7'b1);
      chk("stale_keeps_band", 7'(bands), 7'b1000);
      send(2, 0, 0, 0);
      chk("stale_cleared", {6'b0, stale}, 7'b0);

      send(4, 5, 0, 0);
      send(9, 15, 0, 0);
      send(4, 5, 0, 0);
      chk("bad_keeps_upcnt", 7'(bands), 7'b0100);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
